stack_ctrl: RTL and testbench

Control unit for the 8-entry pushdown stack register bank. Holds the stack pointer and decodes push/pop/clear requests into a 3-bit write index plus write enable, which feed the bank's 3-to-8 one-hot write decoder. Also drives the 3-bit read index of the top-of-stack entry. Reports full/empty, sticky overflow/underflow errors and a high-water mark. The block holds no data storage.

---
 rtl/stack_ctrl_if.sv | 37 +++
 rtl/stack_ctrl.sv | 99 +++++++++
 tb/tb_stack_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Bundle between the stack controller and its user / register bank.
//   master: drives push/pop/clr requests, observes indices and status
//   slave : the controller; consumes requests, drives wr_idx/wr_en, rd_idx and status
// Signals:
//   push, pop, clr      request inputs to the controller
//   wr_idx, wr_en       write decoder index / enable (combinational)
//   rd_idx, rd_valid    top-of-stack index and validity
//   count, full, empty  occupancy
//   overflow, underflow sticky error flags
//   hwm                 high-water mark of count
interface stack_ctrl_if #(
  parameter int unsigned AW = 3
);
  logic          push;
  logic          pop;
  logic          clr;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [AW-1:0] rd_idx;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
  logic [AW:0]   hwm;

  modport master (
    output push, pop, clr,
    input  wr_idx, wr_en, rd_idx, rd_valid, count, full, empty, overflow, underflow, hwm
  );

  modport slave (
    input  push, pop, clr,
    output wr_idx, wr_en, rd_idx, rd_valid, count, full, empty, overflow, underflow, hwm
  );
endinterface

// File: rtl/stack_ctrl.sv
// Control unit for a 2**AW-entry pushdown stack register bank. Holds the stack
// pointer (count), decodes push/pop/clr into a write index + enable for the
// bank's one-hot write decoder, and drives the top-of-stack read index.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   ctrl_io  stack_ctrl_if.slave bundle (requests in, indices/status out)
module stack_ctrl #(
  parameter int unsigned AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  stack_ctrl_if.slave  ctrl_io
);

  localparam logic [AW:0] DepthVal = {1'b1, {AW{1'b0}}};

  logic [AW:0]   count_q, count_d;
  logic [AW:0]   hwm_q, hwm_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [AW-1:0] wr_idx_c;
  logic          wr_en_c;
  logic          full_c, empty_c;

  assign full_c  = (count_q == DepthVal);
  assign empty_c = (count_q == '0);

  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    wr_idx_c = count_q[AW-1:0];
    wr_en_c  = 1'b0;

    if (ctrl_io.clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (ctrl_io.push && ctrl_io.pop && !empty_c) begin
      // Replace top: rd_idx_q always holds count-1 while non-empty.
      wr_idx_c = rd_idx_q;
      wr_en_c  = 1'b1;
    end else if (ctrl_io.push && !full_c) begin
      // Also covers push&pop on an empty stack.
      wr_en_c = 1'b1;
      count_d = count_q + (AW+1)'(1);
    end else if (ctrl_io.push) begin
      ovf_d = 1'b1;
    end else if (ctrl_io.pop && !empty_c) begin
      count_d = count_q - (AW+1)'(1);
    end else if (ctrl_io.pop) begin
      unf_d = 1'b1;
    end

    if (ctrl_io.clr) begin
      hwm_d = '0;
    end else begin
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end

    // Low bits of count-1; a full stack (low bits 0) wraps to the last entry.
    if (count_d == '0) begin
      rd_idx_d = '0;
    end else begin
      rd_idx_d = count_d[AW-1:0] - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      hwm_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      count_q  <= count_d;
      hwm_q    <= hwm_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Gate with rst_n so a write is aborted the instant reset asserts.
  assign ctrl_io.wr_en     = wr_en_c & rst_n;
  assign ctrl_io.wr_idx    = wr_idx_c;
  assign ctrl_io.rd_idx    = rd_idx_q;
  assign ctrl_io.rd_valid  = ~empty_c;
  assign ctrl_io.count     = count_q;
  assign ctrl_io.full      = full_c;
  assign ctrl_io.empty     = empty_c;
  assign ctrl_io.overflow  = ovf_q;
  assign ctrl_io.underflow = unf_q;
  assign ctrl_io.hwm       = hwm_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a stimulus process drives requests and pushes
// the expected response (from a queue-based stack model) into a scoreboard; a
// monitor pops and compares on the falling edge.
module tb_stack_ctrl;

  localparam int unsigned AW    = 3;
  localparam int          Depth = 1 << AW;

  typedef struct {
    int wr_en;
    int wr_idx;
    int rd_idx;
    int rd_valid;
    int count;
    int full;
    int empty;
    int ovf;
    int unf;
    int hwm;
  } exp_t;

  logic clk;
  logic rst_n;

  stack_ctrl_if #(.AW(AW)) bus ();

  stack_ctrl #(.AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stack contents themselves plus sticky state.
  int   stk[$];
  int   m_hwm;
  bit   m_ovf;
  bit   m_unf;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t status_now();
    exp_t e;
    e.count    = stk.size();
    e.rd_idx   = (stk.size() == 0) ? 0 : stk.size() - 1;
    e.rd_valid = (stk.size() != 0);
    e.full     = (stk.size() == Depth);
    e.empty    = (stk.size() == 0);
    e.ovf      = m_ovf;
    e.unf      = m_unf;
    e.hwm      = m_hwm;
    e.wr_en    = 0;
    e.wr_idx   = 0;
    return e;
  endfunction

  task automatic model_reset();
    stk.delete();
    m_hwm = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic cmp_all(input exp_t e, input string tag);
    chk({tag, ".wr_en"}, int'(bus.wr_en), e.wr_en);
    if (e.wr_en != 0) chk({tag, ".wr_idx"}, int'(bus.wr_idx), e.wr_idx);
    chk({tag, ".rd_idx"}, int'(bus.rd_idx), e.rd_idx);
    chk({tag, ".rd_valid"}, int'(bus.rd_valid), e.rd_valid);
    chk({tag, ".count"}, int'(bus.count), e.count);
    chk({tag, ".full"}, int'(bus.full), e.full);
    chk({tag, ".empty"}, int'(bus.empty), e.empty);
    chk({tag, ".overflow"}, int'(bus.overflow), e.ovf);
    chk({tag, ".underflow"}, int'(bus.underflow), e.unf);
    chk({tag, ".hwm"}, int'(bus.hwm), e.hwm);
  endtask

  // One clock: drive requests, queue expectations, then advance the model.
  task automatic cycle(input bit p, input bit q, input bit c);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    bus.push = p;
    bus.pop  = q;
    bus.clr  = c;
    e = status_now();
    n = stk.size();
    if (c) begin
      stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (p && q && n > 0) begin
      e.wr_en  = 1;
      e.wr_idx = n - 1;
      stk[n-1] = int'($urandom);
    end else if (p && n < Depth) begin
      e.wr_en  = 1;
      e.wr_idx = n;
      stk.push_back(int'($urandom));
    end else if (p) begin
      m_ovf = 1;
    end else if (q && n > 0) begin
      void'(stk.pop_back());
    end else if (q) begin
      m_unf = 1;
    end
    if (c) m_hwm = 0;
    else if (stk.size() > m_hwm) m_hwm = stk.size();
    sb.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp_all(e, "cyc");
    end
  end

  initial begin
    exp_t e;
    int   wait_cnt;
    rst_n    = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.clr  = 1'b0;
    model_reset();
    #22;
    rst_n = 1'b1;

    repeat (3) cycle(0, 0, 0);
    repeat (8) cycle(1, 0, 0);
    cycle(1, 0, 0);          // push while full -> overflow
    cycle(0, 1, 0);          // pop, overflow stays
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (3) cycle(1, 0, 0);
    cycle(1, 1, 0);          // replace top at count 3
    cycle(0, 0, 1);
    cycle(1, 1, 0);          // push&pop from empty
    cycle(0, 1, 0);
    cycle(0, 1, 0);          // underflow
    cycle(0, 0, 0);
    cycle(1, 0, 1);          // clr beats push
    cycle(0, 0, 0);
    repeat (5) cycle(1, 0, 0);
    repeat (2) cycle(0, 1, 0);

    // Asynchronous reset mid-cycle while a push is being requested.
    @(negedge clk);
    #1;
    bus.push = 1'b1;
    bus.pop  = 1'b0;
    bus.clr  = 1'b0;
    #1;
    chk("pre_rst.wr_en", int'(bus.wr_en), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    e = status_now();
    cmp_all(e, "async_rst");
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    bus.push = 1'b0;
    cycle(0, 0, 0);
    cycle(1, 0, 0);

    // Randomized traffic; clr kept rare so the stack reaches full and empty.
    for (int i = 0; i < 600; i++) begin
      bit p, q, c;
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 2);
      cycle(p, q, c);
    end
    cycle(0, 0, 0);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
